band_power_streamer: RTL and testbench

Receiving end of the PSD feature path: captures the five band-power words that `psd_top` presents on its `o_power_valid` pulse, buffers up to two epochs of features in a ping-pong store, and streams them out one band per beat on a valid/ready interface toward the classifier. Negative powers are clamped to zero, each epoch carries a sequence tag, and epochs that cannot be buffered are dropped and counted rather than stalling the PSD pipeline, which has no backpressure.

---
 rtl/band_power_streamer.sv | 186 ++++++++++++++++++
 tb/tb_band_power_streamer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/band_power_streamer.sv
// band_power_streamer
// Captures the five band-power words of each PSD epoch into a two-entry
// ping-pong store and streams them out one band per beat (valid/ready).
// Negative powers are clamped to zero. Each epoch carries a sequence tag.
// Epochs arriving while both entries are occupied are dropped and counted,
// because the PSD pipeline upstream cannot be stalled.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   en                  capture enable (gates new epochs only)
//   i_power_valid       one-cycle strobe qualifying the five band inputs
//   i_*_power           signed band powers (delta, theta, alpha, beta, gamma)
//   o_feat_valid/ready  stream handshake
//   o_feat_data         clamped band power of the current beat
//   o_feat_band         band index 0..4
//   o_feat_last         high on the band-4 beat
//   o_feat_tag          sequence tag of the epoch being streamed
//   o_drop_cnt          saturating count of dropped epochs
//   o_overflow          sticky drop flag
//   i_clr_overflow      synchronous clear of o_overflow and o_drop_cnt
module band_power_streamer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  i_power_valid,
    input  logic [DATA_WIDTH-1:0] i_delta_power,
    input  logic [DATA_WIDTH-1:0] i_theta_power,
    input  logic [DATA_WIDTH-1:0] i_alpha_power,
    input  logic [DATA_WIDTH-1:0] i_beta_power,
    input  logic [DATA_WIDTH-1:0] i_gamma_power,
    output logic                  o_feat_valid,
    input  logic                  i_feat_ready,
    output logic [DATA_WIDTH-1:0] o_feat_data,
    output logic [2:0]            o_feat_band,
    output logic                  o_feat_last,
    output logic [TAG_WIDTH-1:0]  o_feat_tag,
    output logic [7:0]            o_drop_cnt,
    output logic                  o_overflow,
    input  logic                  i_clr_overflow
);

    localparam int unsigned NBANDS   = 5;
    localparam int unsigned NENTRIES = 2;
    localparam int unsigned BAND_W   = 3;
    localparam int unsigned CNT_W    = 8;

    // Occupancy of the ping-pong store doubles as the entry count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_e;

    occ_e                  r_state;
    occ_e                  w_state_nxt;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [BAND_W-1:0]     r_band_idx;
    logic [TAG_WIDTH-1:0]  r_tag_cnt;
    logic [DATA_WIDTH-1:0] r_data [NENTRIES][NBANDS];
    logic [TAG_WIDTH-1:0]  r_tag  [NENTRIES];
    logic [CNT_W-1:0]      r_drop_cnt;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_raw   [NBANDS];
    logic [DATA_WIDTH-1:0] w_clamp [NBANDS];
    logic                  w_xfer;
    logic                  w_last_xfer;
    logic                  w_strobe;
    logic                  w_free;
    logic                  w_capture;
    logic                  w_drop;

    assign w_raw[0] = i_delta_power;
    assign w_raw[1] = i_theta_power;
    assign w_raw[2] = i_alpha_power;
    assign w_raw[3] = i_beta_power;
    assign w_raw[4] = i_gamma_power;

    // Clamp negative powers to zero.
    always_comb begin
        for (int unsigned b = 0; b < NBANDS; b++) begin
            w_clamp[b] = w_raw[b][DATA_WIDTH-1] ? '0 : w_raw[b];
        end
    end

    assign w_xfer      = o_feat_valid & i_feat_ready;
    assign w_last_xfer = w_xfer & (r_band_idx == BAND_W'(NBANDS - 1));
    assign w_strobe    = en & i_power_valid;
    // A full store still frees a slot when its oldest epoch finishes this cycle.
    assign w_free      = (r_state != S_FULL) | w_last_xfer;
    assign w_capture   = w_strobe & w_free;
    assign w_drop      = w_strobe & ~w_free;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next state: +1 on capture, -1 on last beat, both cancel.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_capture) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_capture && !w_last_xfer)      w_state_nxt = S_FULL;
                else if (!w_capture && w_last_xfer) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_last_xfer && !w_capture) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Pointers, band index and tag counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_band_idx <= '0;
            r_tag_cnt  <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr  <= ~r_wr_ptr;
                r_tag_cnt <= r_tag_cnt + TAG_WIDTH'(1);
            end
            if (w_last_xfer) begin
                r_band_idx <= '0;
                r_rd_ptr   <= ~r_rd_ptr;
            end else if (w_xfer) begin
                r_band_idx <= r_band_idx + BAND_W'(1);
            end
        end
    end

    // Epoch storage. When FULL and capturing on the last beat, wr_ptr equals
    // rd_ptr: the entry being overwritten is the one finishing this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned e = 0; e < NENTRIES; e++) begin
                r_tag[e] <= '0;
                for (int unsigned b = 0; b < NBANDS; b++) begin
                    r_data[e][b] <= '0;
                end
            end
        end else if (w_capture) begin
            r_tag[r_wr_ptr] <= r_tag_cnt;
            for (int unsigned b = 0; b < NBANDS; b++) begin
                r_data[r_wr_ptr][b] <= w_clamp[b];
            end
        end
    end

    // Drop accounting; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_clr_overflow) begin
                r_drop_cnt <= CNT_W'(1);
            end else if (r_drop_cnt != {CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end else if (i_clr_overflow) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end
    end

    assign o_feat_valid = (r_state != S_EMPTY);
    assign o_feat_data  = r_data[r_rd_ptr][r_band_idx];
    assign o_feat_tag   = r_tag[r_rd_ptr];
    assign o_feat_band  = r_band_idx;
    assign o_feat_last  = (r_band_idx == BAND_W'(NBANDS - 1));
    assign o_drop_cnt   = r_drop_cnt;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_band_power_streamer.sv
// Scoreboarded bench for band_power_streamer: directed epochs push expected
// beats into a queue, a negedge monitor pops and compares on each handshake
// and checks that stalled beats hold stable.
module tb_band_power_streamer;

    logic               clk;
    logic               rst;
    logic               en;
    logic               i_power_valid;
    logic signed [31:0] i_delta_power, i_theta_power, i_alpha_power, i_beta_power, i_gamma_power;
    logic               o_feat_valid;
    logic               i_feat_ready;
    logic [31:0]        o_feat_data;
    logic [2:0]         o_feat_band;
    logic               o_feat_last;
    logic [7:0]         o_feat_tag;
    logic [7:0]         o_drop_cnt;
    logic               o_overflow;
    logic               i_clr_overflow;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  band;
        logic        last;
        logic [7:0]  tag;
    } beat_t;

    beat_t expq[$];
    int    total = 0;
    int    bad   = 0;

    band_power_streamer #(.DATA_WIDTH(32), .TAG_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .i_power_valid  (i_power_valid),
        .i_delta_power  (i_delta_power),
        .i_theta_power  (i_theta_power),
        .i_alpha_power  (i_alpha_power),
        .i_beta_power   (i_beta_power),
        .i_gamma_power  (i_gamma_power),
        .o_feat_valid   (o_feat_valid),
        .i_feat_ready   (i_feat_ready),
        .o_feat_data    (o_feat_data),
        .o_feat_band    (o_feat_band),
        .o_feat_last    (o_feat_last),
        .o_feat_tag     (o_feat_tag),
        .o_drop_cnt     (o_drop_cnt),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected beats of one captured epoch (values already clamped by hand).
    task automatic push_epoch(input logic [7:0] tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
        logic [31:0] ev [5];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3; ev[4] = e4;
        for (int b = 0; b < 5; b++) begin
            expq.push_back('{data: ev[b], band: 3'(b), last: (b == 4), tag: tag});
        end
    endtask

    // One-cycle power strobe; called right after a posedge, returns #1 after the next.
    task automatic strobe(input int p0, input int p1, input int p2, input int p3, input int p4);
        i_power_valid = 1'b1;
        i_delta_power = p0; i_theta_power = p1; i_alpha_power = p2;
        i_beta_power  = p3; i_gamma_power = p4;
        @(posedge clk); #1;
        i_power_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_remaining", 64'(expq.size()), 64'd0);
    endtask

    // Monitor: compares each transferred beat and checks stall stability.
    logic        held;
    logic [43:0] held_val;
    initial held = 1'b0;
    always @(negedge clk) begin
        beat_t exp_b;
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (held) chk("stall_stable", 64'({o_feat_data, o_feat_band, o_feat_last, o_feat_tag}), 64'(held_val));
            if (o_feat_valid && i_feat_ready) begin
                held = 1'b0;
                if (expq.size() == 0) begin
                    chk("unexpected_beat_band", 64'(o_feat_band), 64'd7);
                end else begin
                    exp_b = expq.pop_front();
                    chk("beat_data", 64'(o_feat_data), 64'(exp_b.data));
                    chk("beat_band", 64'(o_feat_band), 64'(exp_b.band));
                    chk("beat_last", 64'(o_feat_last), 64'(exp_b.last));
                    chk("beat_tag",  64'(o_feat_tag),  64'(exp_b.tag));
                end
            end else if (o_feat_valid) begin
                held     = 1'b1;
                held_val = {o_feat_data, o_feat_band, o_feat_last, o_feat_tag};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b1; i_power_valid = 1'b0; i_feat_ready = 1'b0; i_clr_overflow = 1'b0;
        i_delta_power = 0; i_theta_power = 0; i_alpha_power = 0; i_beta_power = 0; i_gamma_power = 0;
        cycles(3);
        chk("rst_valid", 64'(o_feat_valid), 64'd0);
        chk("rst_data",  64'(o_feat_data),  64'd0);
        chk("rst_band",  64'(o_feat_band),  64'd0);
        chk("rst_last",  64'(o_feat_last),  64'd0);
        chk("rst_tag",   64'(o_feat_tag),   64'd0);
        chk("rst_drop",  64'(o_drop_cnt),   64'd0);
        chk("rst_ovf",   64'(o_overflow),   64'd0);
        rst = 1'b1;
        cycles(2);

        // Single epoch, ready high, first beat the cycle after the strobe.
        i_feat_ready = 1'b1;
        push_epoch(8'd0, 32'd100, 32'd200, 32'd0, 32'd400, 32'd500);
        strobe(100, 200, -5, 400, 500);
        chk("latency_valid", 64'(o_feat_valid), 64'd1);
        chk("latency_band",  64'(o_feat_band),  64'd0);
        wait_drain();

        // Backpressure: ready toggles every cycle.
        i_feat_ready = 1'b0;
        push_epoch(8'd1, 32'd7, 32'h7fff_ffff, 32'd0, 32'd3, 32'd0);
        strobe(7, 32'h7fff_ffff, 32'h8000_0000, 3, -1);
        for (int i = 0; i < 14; i++) begin
            i_feat_ready = ~i_feat_ready;
            cycles(1);
        end
        i_feat_ready = 1'b1;
        wait_drain();

        // Overflow: fresh reset, three strobes with ready low.
        rst = 1'b0; cycles(2); rst = 1'b1; cycles(1);
        i_feat_ready = 1'b0;
        push_epoch(8'd0, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15);
        strobe(11, 12, 13, 14, 15);
        push_epoch(8'd1, 32'd21, 32'd0, 32'd23, 32'd24, 32'd25);
        strobe(21, -22, 23, 24, 25);
        strobe(31, 32, 33, 34, 35);
        chk("ovf_flag", 64'(o_overflow), 64'd1);
        chk("ovf_drop", 64'(o_drop_cnt), 64'd1);
        i_feat_ready = 1'b1;
        wait_drain();
        push_epoch(8'd2, 32'd41, 32'd42, 32'd43, 32'd44, 32'd45);
        strobe(41, 42, 43, 44, 45);
        wait_drain();

        // Clear, then FULL store with a strobe on the last-beat handshake.
        i_clr_overflow = 1'b1; cycles(1); i_clr_overflow = 1'b0;
        chk("clr_flag", 64'(o_overflow), 64'd0);
        chk("clr_drop", 64'(o_drop_cnt), 64'd0);
        i_feat_ready = 1'b0;
        push_epoch(8'd3, 32'd51, 32'd52, 32'd53, 32'd54, 32'd55);
        strobe(51, 52, 53, 54, 55);
        push_epoch(8'd4, 32'd61, 32'd62, 32'd63, 32'd64, 32'd65);
        strobe(61, 62, 63, 64, 65);
        cycles(2);
        i_feat_ready = 1'b1;
        cycles(4);
        chk("pre_last_band", 64'(o_feat_band), 64'd4);
        push_epoch(8'd5, 32'd71, 32'd72, 32'd73, 32'd74, 32'd75);
        strobe(71, 72, 73, 74, 75);
        chk("simul_valid", 64'(o_feat_valid), 64'd1);
        chk("simul_drop",  64'(o_drop_cnt),   64'd0);
        chk("simul_ovf",   64'(o_overflow),   64'd0);
        wait_drain();

        // Gating: strobe with en low produces nothing and is not a drop.
        en = 1'b0;
        strobe(81, 82, 83, 84, 85);
        cycles(3);
        chk("gate_valid", 64'(o_feat_valid), 64'd0);
        chk("gate_drop",  64'(o_drop_cnt),   64'd0);
        en = 1'b1;

        // Reset asserted while band 2 is on the bus.
        i_feat_ready = 1'b0;
        push_epoch(8'd6, 32'd91, 32'd92, 32'd93, 32'd94, 32'd95);
        strobe(91, 92, 93, 94, 95);
        i_feat_ready = 1'b1;
        cycles(2);
        i_feat_ready = 1'b0;
        chk("mid_band", 64'(o_feat_band), 64'd2);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(o_feat_valid), 64'd0);
        chk("arst_data",  64'(o_feat_data),  64'd0);
        chk("arst_band",  64'(o_feat_band),  64'd0);
        chk("arst_tag",   64'(o_feat_tag),   64'd0);
        expq.delete();
        cycles(2);
        rst = 1'b1;
        i_feat_ready = 1'b1;
        cycles(3);
        chk("post_rst_valid", 64'(o_feat_valid), 64'd0);

        // Saturation: fill, then 300 back-to-back drops.
        i_feat_ready = 1'b0;
        push_epoch(8'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        strobe(1, 2, 3, 4, 5);
        push_epoch(8'd1, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10);
        strobe(6, 7, 8, 9, 10);
        for (int i = 0; i < 300; i++) strobe(i, i, i, i, i);
        chk("sat_drop", 64'(o_drop_cnt), 64'd255);
        chk("sat_ovf",  64'(o_overflow), 64'd1);
        i_clr_overflow = 1'b1; cycles(1); i_clr_overflow = 1'b0;
        chk("sat_clr_drop", 64'(o_drop_cnt), 64'd0);
        chk("sat_clr_ovf",  64'(o_overflow), 64'd0);
        i_clr_overflow = 1'b1;
        strobe(9, 9, 9, 9, 9);
        i_clr_overflow = 1'b0;
        chk("clr_vs_drop_cnt", 64'(o_drop_cnt), 64'd1);
        chk("clr_vs_drop_ovf", 64'(o_overflow), 64'd1);
        i_feat_ready = 1'b1;
        wait_drain();
        cycles(2);
        chk("end_valid", 64'(o_feat_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
